fc_layer_engine: RTL and testbench

Fabric-side responder for one fully connected network layer. It executes the ready/done/state layer-control conduit exported by the HPS system: it waits for `ready`, reads 8-bit weights and activations through two exported on-chip-memory master ports, and runs one multiply-accumulate per cycle. For each output neuron it applies bias, shift, ReLU and saturation, and writes one 8-bit result per neuron back to activation memory. It then signals `done` and holds it until the HPS releases `ready`. One instance is placed per layer.

---
 rtl/fc_layer_engine_if.sv | 42 ++++
 rtl/fc_layer_engine.sv | 239 +++++++++++++++++++++++
 tb/tb_fc_layer_engine.sv | 494 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fc_layer_engine_if.sv
// Bundle of the layer-control conduit (ready/done/state) and the two
// on-chip-memory master ports used by one fully connected layer engine.
interface fc_layer_engine_if #(
  parameter int W_AW = 17,
  parameter int A_AW = 11
) ();
  logic            ready;
  logic            done;
  logic [3:0]      state;
  logic [W_AW-1:0] w_address;
  logic            w_chipselect;
  logic            w_clken;
  logic            w_write;
  logic [7:0]      w_writedata;
  logic [7:0]      w_readdata;
  logic [A_AW-1:0] a_address;
  logic            a_chipselect;
  logic            a_clken;
  logic            a_write;
  logic [7:0]      a_writedata;
  logic [7:0]      a_readdata;

  // Engine side: drives the memory ports and the done/state conduit.
  modport master (
    input  ready,
    output done, state,
    output w_address, w_chipselect, w_clken, w_write, w_writedata,
    input  w_readdata,
    output a_address, a_chipselect, a_clken, a_write, a_writedata,
    input  a_readdata
  );

  // System side: HPS control plus the two memories.
  modport slave (
    output ready,
    input  done, state,
    input  w_address, w_chipselect, w_clken, w_write, w_writedata,
    output w_readdata,
    input  a_address, a_chipselect, a_clken, a_write, a_writedata,
    output a_readdata
  );
endinterface

// File: rtl/fc_layer_engine.sv
// Fully connected layer engine. On a ready request it walks every output
// neuron: loads the bias, runs one multiply-accumulate per cycle over all
// inputs, then shifts, applies ReLU, saturates to 8 bits and writes the
// result back to activation memory. Raises done once the layer finishes.
module fc_layer_engine #(
  parameter int N_IN       = 784,
  parameter int N_OUT      = 100,
  parameter int W_AW       = 17,
  parameter int A_AW       = 11,
  parameter int W_BASE     = 0,
  parameter int IN_BASE    = 0,
  parameter int OUT_BASE   = 1024,
  parameter int SHIFT      = 8,
  parameter int BIAS_SHIFT = 8
) (
  input logic               clk,
  input logic               reset_n,
  fc_layer_engine_if.master bus
);

  localparam int IW = $clog2(N_IN + 1);
  localparam int JW = $clog2(N_OUT + 1);

  localparam logic [IW-1:0]   I_LAST    = IW'(N_IN - 1);
  localparam logic [JW-1:0]   J_LAST    = JW'(N_OUT - 1);
  localparam logic [W_AW-1:0] W_START   = W_AW'(W_BASE);
  // Biases sit right after the last weight row.
  localparam logic [W_AW-1:0] BIAS_BASE = W_AW'(W_BASE + N_OUT * N_IN);
  localparam logic [A_AW-1:0] IN_START  = A_AW'(IN_BASE);
  localparam logic [A_AW-1:0] OUT_START = A_AW'(OUT_BASE);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_BIAS  = 4'd1,
    S_MAC   = 4'd2,
    S_DRAIN = 4'd3,
    S_WRITE = 4'd4,
    S_DONE  = 4'd5
  } state_t;

  // Bias is sign-extended to accumulator width and pre-scaled.
  function automatic logic signed [31:0] bias_init(input logic [7:0] b);
    logic signed [31:0] ext;
    ext = 32'(signed'(b));
    return ext <<< BIAS_SHIFT;
  endfunction

  // Signed weight times unsigned activation (zero-extended to 9 bits).
  function automatic logic signed [31:0] mac_term(input logic [7:0] w,
                                                  input logic [7:0] a);
    logic signed [16:0] ws;
    logic signed [16:0] as;
    logic signed [16:0] p;
    ws = 17'(signed'(w));
    as = 17'(signed'({1'b0, a}));
    p  = ws * as;
    return 32'(p);
  endfunction

  // Floor shift, ReLU and clamp to the 8-bit activation range.
  function automatic logic [7:0] relu_sat(input logic signed [31:0] acc);
    logic signed [31:0] r;
    r = acc >>> SHIFT;
    if (r < 32'sd0) begin
      return 8'd0;
    end else if (r > 32'sd255) begin
      return 8'd255;
    end else begin
      return r[7:0];
    end
  endfunction

  state_t             state_q, state_d;
  logic [JW-1:0]      j_q, j_d;
  logic [IW-1:0]      i_q, i_d;
  logic [W_AW-1:0]    wcnt_q, wcnt_d;
  logic signed [31:0] acc_q, acc_d;
  logic signed [31:0] term_s;
  logic               done_q, done_d;
  logic               w_cs_q, w_cs_d;
  logic               a_cs_q, a_cs_d;
  logic               a_wr_q, a_wr_d;
  logic [W_AW-1:0]    w_addr_q, w_addr_d;
  logic [A_AW-1:0]    a_addr_q, a_addr_d;
  logic [7:0]         a_wdata_q, a_wdata_d;

  assign term_s = mac_term(bus.w_readdata, bus.a_readdata);

  // Next-state and next-output logic; outputs are computed for the state
  // being entered so that every port comes straight from a flop.
  always_comb begin
    state_d   = state_q;
    j_d       = j_q;
    i_d       = i_q;
    wcnt_d    = wcnt_q;
    acc_d     = acc_q;
    done_d    = 1'b0;
    w_cs_d    = 1'b0;
    a_cs_d    = 1'b0;
    a_wr_d    = 1'b0;
    w_addr_d  = w_addr_q;
    a_addr_d  = a_addr_q;
    a_wdata_d = a_wdata_q;

    case (state_q)
      S_IDLE: begin
        if (bus.ready) begin
          j_d      = '0;
          wcnt_d   = W_START;
          w_cs_d   = 1'b1;
          w_addr_d = BIAS_BASE;
          state_d  = S_BIAS;
        end else begin
          state_d  = S_IDLE;
        end
      end

      S_BIAS: begin
        // Issue weight (j,0) and input 0 for the first MAC cycle.
        i_d      = '0;
        w_cs_d   = 1'b1;
        a_cs_d   = 1'b1;
        w_addr_d = wcnt_q;
        wcnt_d   = wcnt_q + W_AW'(1);
        a_addr_d = IN_START;
        state_d  = S_MAC;
      end

      S_MAC: begin
        // Data arriving now belongs to the previous issue (bias when i=0).
        if (i_q == '0) begin
          acc_d = bias_init(bus.w_readdata);
        end else begin
          acc_d = acc_q + term_s;
        end
        if (i_q == I_LAST) begin
          state_d = S_DRAIN;
        end else begin
          i_d      = i_q + IW'(1);
          w_cs_d   = 1'b1;
          a_cs_d   = 1'b1;
          w_addr_d = wcnt_q;
          wcnt_d   = wcnt_q + W_AW'(1);
          a_addr_d = IN_START + A_AW'(i_q + IW'(1));
          state_d  = S_MAC;
        end
      end

      S_DRAIN: begin
        // Fold in the last product and prepare the write beat.
        acc_d     = acc_q + term_s;
        a_cs_d    = 1'b1;
        a_wr_d    = 1'b1;
        a_addr_d  = OUT_START + A_AW'(j_q);
        a_wdata_d = relu_sat(acc_d);
        state_d   = S_WRITE;
      end

      S_WRITE: begin
        if (j_q == J_LAST) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          j_d      = j_q + JW'(1);
          w_cs_d   = 1'b1;
          w_addr_d = BIAS_BASE + W_AW'(j_q + JW'(1));
          state_d  = S_BIAS;
        end
      end

      S_DONE: begin
        // Holding here while ready stays high gives one job per request.
        if (bus.ready) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          done_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath counters, accumulator and registered port outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      j_q       <= '0;
      i_q       <= '0;
      wcnt_q    <= '0;
      acc_q     <= 32'sd0;
      done_q    <= 1'b0;
      w_cs_q    <= 1'b0;
      a_cs_q    <= 1'b0;
      a_wr_q    <= 1'b0;
      w_addr_q  <= '0;
      a_addr_q  <= '0;
      a_wdata_q <= 8'd0;
    end else begin
      j_q       <= j_d;
      i_q       <= i_d;
      wcnt_q    <= wcnt_d;
      acc_q     <= acc_d;
      done_q    <= done_d;
      w_cs_q    <= w_cs_d;
      a_cs_q    <= a_cs_d;
      a_wr_q    <= a_wr_d;
      w_addr_q  <= w_addr_d;
      a_addr_q  <= a_addr_d;
      a_wdata_q <= a_wdata_d;
    end
  end

  assign bus.state        = state_q;
  assign bus.done         = done_q;
  assign bus.w_address    = w_addr_q;
  assign bus.w_chipselect = w_cs_q;
  assign bus.w_clken      = 1'b1;
  assign bus.w_write      = 1'b0;
  assign bus.w_writedata  = 8'd0;
  assign bus.a_address    = a_addr_q;
  assign bus.a_chipselect = a_cs_q;
  assign bus.a_clken      = 1'b1;
  assign bus.a_write      = a_wr_q;
  assign bus.a_writedata  = a_wdata_q;

endmodule

// File: tb/tb_fc_layer_engine.sv
// Bench for fc_layer_engine: two instances (4x2 and 3x2 layers) with
// behavioural memories, write/address logs and an arithmetic reference.
module tb_fc_layer_engine;

  localparam int WAW    = 8;
  localparam int AAW    = 6;
  localparam int A_NIN  = 4;
  localparam int A_NOUT = 2;
  localparam int A_SH   = 2;
  localparam int A_BS   = 0;
  localparam int A_OUT  = 16;
  localparam int B_NIN  = 3;
  localparam int B_NOUT = 2;
  localparam int B_SH   = 2;
  localparam int B_BS   = 2;
  localparam int B_OUT  = 16;
  localparam int A_JOB  = A_NOUT * (A_NIN + 3);
  localparam int B_JOB  = B_NOUT * (B_NIN + 3);
  localparam int BOUND  = 200;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  fc_layer_engine_if #(.W_AW(WAW), .A_AW(AAW)) ifa ();
  fc_layer_engine_if #(.W_AW(WAW), .A_AW(AAW)) ifb ();

  fc_layer_engine #(
    .N_IN(A_NIN), .N_OUT(A_NOUT), .W_AW(WAW), .A_AW(AAW), .W_BASE(0),
    .IN_BASE(0), .OUT_BASE(A_OUT), .SHIFT(A_SH), .BIAS_SHIFT(A_BS)
  ) dut_a (.clk(clk), .reset_n(reset_n), .bus(ifa));

  fc_layer_engine #(
    .N_IN(B_NIN), .N_OUT(B_NOUT), .W_AW(WAW), .A_AW(AAW), .W_BASE(0),
    .IN_BASE(0), .OUT_BASE(B_OUT), .SHIFT(B_SH), .BIAS_SHIFT(B_BS)
  ) dut_b (.clk(clk), .reset_n(reset_n), .bus(ifb));

  logic [7:0]     wmem_a [0:255];
  logic [7:0]     ain_a  [0:63];
  logic [7:0]     wmem_b [0:255];
  logic [7:0]     ain_b  [0:63];
  logic [AAW-1:0] wr_addr_a [0:255];
  logic [7:0]     wr_data_a [0:255];
  logic [AAW-1:0] wr_addr_b [0:255];
  logic [WAW-1:0] wlog_b    [0:255];
  int wr_cnt_a = 0;
  int wr_cnt_b = 0;
  int wl_cnt_b = 0;
  int viol_a = 0;
  int viol_b = 0;

  // Memory model and logger for instance A.
  always @(posedge clk) begin
    if (ifa.w_chipselect) ifa.w_readdata <= wmem_a[ifa.w_address];
    if (ifa.a_chipselect && !ifa.a_write) ifa.a_readdata <= ain_a[ifa.a_address];
    if (ifa.a_chipselect && ifa.a_write) begin
      wr_addr_a[wr_cnt_a[7:0]] <= ifa.a_address;
      wr_data_a[wr_cnt_a[7:0]] <= ifa.a_writedata;
      wr_cnt_a <= wr_cnt_a + 1;
    end
    if (ifa.a_write && ifa.w_chipselect) viol_a <= viol_a + 1;
  end

  // Memory model and logger for instance B.
  always @(posedge clk) begin
    if (ifb.w_chipselect) begin
      ifb.w_readdata <= wmem_b[ifb.w_address];
      wlog_b[wl_cnt_b[7:0]] <= ifb.w_address;
      wl_cnt_b <= wl_cnt_b + 1;
    end
    if (ifb.a_chipselect && !ifb.a_write) ifb.a_readdata <= ain_b[ifb.a_address];
    if (ifb.a_chipselect && ifb.a_write) begin
      wr_addr_b[wr_cnt_b[7:0]] <= ifb.a_address;
      wr_cnt_b <= wr_cnt_b + 1;
    end
    if (ifb.a_write && ifb.w_chipselect) viol_b <= viol_b + 1;
  end

  // Reference: y_j = clamp(floor((bias*2^BS + sum w*a) / 2^SHIFT), 0, 255).
  function automatic int ref_a(input int j);
    longint acc;
    longint d;
    longint q;
    int     b_idx;
    b_idx = A_NOUT * A_NIN + j;
    acc = longint'($signed(wmem_a[b_idx[7:0]])) * longint'(2 ** A_BS);
    for (int i = 0; i < A_NIN; i++) begin
      int w_idx;
      w_idx = j * A_NIN + i;
      acc = acc + longint'($signed(wmem_a[w_idx[7:0]])) * longint'(ain_a[i[5:0]]);
    end
    d = longint'(2 ** A_SH);
    q = acc / d;
    if ((acc % d != 0) && (acc < 0)) q = q - 1;
    if (q < 0) return 0;
    else if (q > 255) return 255;
    else return int'(q);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_random_a();
    for (int k = 0; k < A_NOUT * A_NIN + A_NOUT; k++) wmem_a[k] = 8'($urandom);
    for (int k = 0; k < A_NIN; k++) ain_a[k] = 8'($urandom);
  endtask

  task automatic test_reset();
    logic [15:0] got [12];
    logic [15:0] exp [12];
    string       nm  [12];
    ifa.ready = 1'b0;
    ifb.ready = 1'b0;
    #2 reset_n = 1'b0;
    repeat (3) tick();
    got = '{16'(ifa.state), 16'(ifa.done), 16'(ifa.w_chipselect),
            16'(ifa.a_chipselect), 16'(ifa.a_write), 16'(ifa.w_address),
            16'(ifa.a_address), 16'(ifa.a_writedata), 16'(ifa.w_clken),
            16'(ifa.a_clken), 16'(ifa.w_write), 16'(ifa.w_writedata)};
    exp = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0,
            16'd1, 16'd1, 16'd0, 16'd0};
    nm  = '{"state", "done", "w_cs", "a_cs", "a_write", "w_addr", "a_addr",
            "a_wdata", "w_clken", "a_clken", "w_write", "w_wdata"};
    for (int k = 0; k < 12; k++) begin
      n_checks++;
      if (got[k] !== exp[k]) begin
        n_fail++;
        $display("FAIL reset_%s: got %0d expected %0d", nm[k], got[k], exp[k]);
      end
    end
    reset_n = 1'b1;
    repeat (2) tick();
    n_checks++;
    if (ifa.state !== 4'd0 || ifb.state !== 4'd0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %0d/%0d expected 0", ifa.state, ifb.state);
    end
  endtask

  task automatic test_basic();
    int edges;
    int start;
    int idx;
    int wv [8] = '{1, 2, 3, 4, -1, -1, -1, -1};
    int av [4] = '{10, 20, 30, 40};
    int ea [2] = '{A_OUT, A_OUT + 1};
    int ed [2] = '{76, 0};
    for (int k = 0; k < 8; k++) wmem_a[k] = 8'(wv[k]);
    wmem_a[8] = 8'd4;
    wmem_a[9] = 8'd0;
    for (int k = 0; k < 4; k++) ain_a[k] = 8'(av[k]);
    start = wr_cnt_a;
    ifa.ready = 1'b1;
    edges = 0;
    for (int k = 0; k < BOUND; k++) begin
      tick();
      if (k == 5) ifa.ready = 1'b0;
      if (ifa.done === 1'b1) break;
      edges++;
    end
    n_checks++;
    if (edges !== A_JOB) begin
      n_fail++;
      $display("FAIL basic_done_edge: got %0d expected %0d", edges, A_JOB);
    end
    n_checks++;
    if (wr_cnt_a - start !== A_NOUT) begin
      n_fail++;
      $display("FAIL basic_write_count: got %0d expected %0d", wr_cnt_a - start, A_NOUT);
    end
    for (int j = 0; j < A_NOUT; j++) begin
      idx = start + j;
      n_checks++;
      if (int'(wr_addr_a[idx[7:0]]) !== ea[j] || int'(wr_data_a[idx[7:0]]) !== ed[j]) begin
        n_fail++;
        $display("FAIL basic_write_%0d: got addr %0d data %0d expected addr %0d data %0d",
                 j, wr_addr_a[idx[7:0]], wr_data_a[idx[7:0]], ea[j], ed[j]);
      end
    end
    tick();
    n_checks++;
    if (ifa.done !== 1'b0 || ifa.state !== 4'd0) begin
      n_fail++;
      $display("FAIL basic_release: got done %0d state %0d expected 0/0", ifa.done, ifa.state);
    end
  endtask

  task automatic test_saturation();
    int edges;
    int start;
    int idx;
    for (int k = 0; k < A_NOUT * A_NIN; k++) wmem_a[k] = 8'd127;
    for (int k = 0; k < A_NOUT; k++) wmem_a[A_NOUT * A_NIN + k] = 8'd0;
    for (int k = 0; k < A_NIN; k++) ain_a[k] = 8'd255;
    start = wr_cnt_a;
    ifa.ready = 1'b1;
    edges = 0;
    for (int k = 0; k < BOUND; k++) begin
      tick();
      if (ifa.done === 1'b1) break;
      edges++;
    end
    ifa.ready = 1'b0;
    n_checks++;
    if (edges !== A_JOB || wr_cnt_a - start !== A_NOUT) begin
      n_fail++;
      $display("FAIL sat_job: got edges %0d writes %0d expected %0d/%0d",
               edges, wr_cnt_a - start, A_JOB, A_NOUT);
    end
    for (int j = 0; j < A_NOUT; j++) begin
      idx = start + j;
      n_checks++;
      if (wr_data_a[idx[7:0]] !== 8'd255) begin
        n_fail++;
        $display("FAIL sat_out_%0d: got %0d expected 255", j, wr_data_a[idx[7:0]]);
      end
    end
    tick();
  endtask

  task automatic test_random();
    int edges;
    int start;
    int idx;
    int exp_y [A_NOUT];
    for (int it = 0; it < 6; it++) begin
      load_random_a();
      for (int j = 0; j < A_NOUT; j++) exp_y[j] = ref_a(j);
      start = wr_cnt_a;
      ifa.ready = 1'b1;
      edges = 0;
      for (int k = 0; k < BOUND; k++) begin
        tick();
        if (ifa.done === 1'b1) break;
        edges++;
      end
      ifa.ready = 1'b0;
      n_checks++;
      if (edges !== A_JOB || wr_cnt_a - start !== A_NOUT) begin
        n_fail++;
        $display("FAIL rand_job_%0d: got edges %0d writes %0d expected %0d/%0d",
                 it, edges, wr_cnt_a - start, A_JOB, A_NOUT);
      end
      for (int j = 0; j < A_NOUT; j++) begin
        idx = start + j;
        n_checks++;
        if (int'(wr_data_a[idx[7:0]]) !== exp_y[j] || int'(wr_addr_a[idx[7:0]]) !== A_OUT + j) begin
          n_fail++;
          $display("FAIL rand_out_%0d_%0d: got addr %0d data %0d expected addr %0d data %0d",
                   it, j, wr_addr_a[idx[7:0]], wr_data_a[idx[7:0]], A_OUT + j, exp_y[j]);
        end
      end
      tick();
    end
  endtask

  task automatic test_handshake();
    int edges;
    int start;
    int idx;
    int bad;
    int exp_y [A_NOUT];
    load_random_a();
    ifa.ready = 1'b1;
    for (int k = 0; k < BOUND; k++) begin
      tick();
      if (ifa.done === 1'b1) break;
    end
    start = wr_cnt_a;
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (ifa.state !== 4'd5 || ifa.done !== 1'b1 || ifa.w_chipselect !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL hold_done: got %0d bad cycles expected 0", bad);
    end
    n_checks++;
    if (wr_cnt_a - start !== 0) begin
      n_fail++;
      $display("FAIL hold_no_writes: got %0d writes expected 0", wr_cnt_a - start);
    end
    ifa.ready = 1'b0;
    tick();
    n_checks++;
    if (ifa.done !== 1'b0 || ifa.state !== 4'd0) begin
      n_fail++;
      $display("FAIL drop_ready: got done %0d state %0d expected 0/0", ifa.done, ifa.state);
    end
    load_random_a();
    for (int j = 0; j < A_NOUT; j++) exp_y[j] = ref_a(j);
    start = wr_cnt_a;
    ifa.ready = 1'b1;
    tick();
    ifa.ready = 1'b0;
    edges = 1;
    for (int k = 0; k < BOUND; k++) begin
      tick();
      if (ifa.done === 1'b1) break;
      edges++;
    end
    n_checks++;
    if (edges !== A_JOB || wr_cnt_a - start !== A_NOUT) begin
      n_fail++;
      $display("FAIL pulse_job: got edges %0d writes %0d expected %0d/%0d",
               edges, wr_cnt_a - start, A_JOB, A_NOUT);
    end
    for (int j = 0; j < A_NOUT; j++) begin
      idx = start + j;
      n_checks++;
      if (int'(wr_data_a[idx[7:0]]) !== exp_y[j]) begin
        n_fail++;
        $display("FAIL pulse_out_%0d: got %0d expected %0d", j, wr_data_a[idx[7:0]], exp_y[j]);
      end
    end
    tick();
  endtask

  task automatic test_reset_mid_job();
    int edges;
    int start;
    int idx;
    int exp_y [A_NOUT];
    load_random_a();
    start = wr_cnt_a;
    ifa.ready = 1'b1;
    repeat (10) tick();
    ifa.ready = 1'b0;
    n_checks++;
    if (ifa.state !== 4'd2) begin
      n_fail++;
      $display("FAIL pre_reset_state: got %0d expected 2", ifa.state);
    end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (ifa.state !== 4'd0 || ifa.done !== 1'b0 || ifa.w_chipselect !== 1'b0 ||
        ifa.a_chipselect !== 1'b0 || ifa.a_write !== 1'b0 || ifa.w_address !== 8'd0 ||
        ifa.a_address !== 6'd0 || ifa.a_writedata !== 8'd0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got state %0d wcs %0d acs %0d wr %0d waddr %0d expected all 0",
               ifa.state, ifa.w_chipselect, ifa.a_chipselect, ifa.a_write, ifa.w_address);
    end
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (2) tick();
    idx = start;
    n_checks++;
    if (wr_cnt_a - start !== 1 || int'(wr_addr_a[idx[7:0]]) !== A_OUT) begin
      n_fail++;
      $display("FAIL mid_reset_writes: got %0d writes first addr %0d expected 1 at %0d",
               wr_cnt_a - start, wr_addr_a[idx[7:0]], A_OUT);
    end
    load_random_a();
    for (int j = 0; j < A_NOUT; j++) exp_y[j] = ref_a(j);
    start = wr_cnt_a;
    ifa.ready = 1'b1;
    edges = 0;
    for (int k = 0; k < BOUND; k++) begin
      tick();
      if (ifa.done === 1'b1) break;
      edges++;
    end
    ifa.ready = 1'b0;
    n_checks++;
    if (edges !== A_JOB) begin
      n_fail++;
      $display("FAIL post_reset_edge: got %0d expected %0d", edges, A_JOB);
    end
    for (int j = 0; j < A_NOUT; j++) begin
      idx = start + j;
      n_checks++;
      if (int'(wr_data_a[idx[7:0]]) !== exp_y[j]) begin
        n_fail++;
        $display("FAIL post_reset_out_%0d: got %0d expected %0d", j, wr_data_a[idx[7:0]], exp_y[j]);
      end
    end
    tick();
  endtask

  task automatic test_bias_shift();
    int edges;
    int start;
    int idx;
    int ed [2] = '{0, 100};
    for (int k = 0; k < B_NOUT * B_NIN; k++) wmem_b[k] = 8'd0;
    wmem_b[6] = 8'h80;
    wmem_b[7] = 8'd100;
    for (int k = 0; k < B_NIN; k++) ain_b[k] = 8'($urandom);
    start = wr_cnt_b;
    ifb.ready = 1'b1;
    edges = 0;
    for (int k = 0; k < BOUND; k++) begin
      tick();
      if (ifb.done === 1'b1) break;
      edges++;
    end
    ifb.ready = 1'b0;
    n_checks++;
    if (edges !== B_JOB) begin
      n_fail++;
      $display("FAIL bshift_done_edge: got %0d expected %0d", edges, B_JOB);
    end
    for (int j = 0; j < B_NOUT; j++) begin
      idx = start + j;
      n_checks++;
      if (int'(dut_b_data(idx)) !== ed[j]) begin
        n_fail++;
        $display("FAIL bshift_out_%0d: got %0d expected %0d", j, dut_b_data(idx), ed[j]);
      end
    end
    tick();
  endtask

  // Written-data log for instance B, kept alongside its address log.
  logic [7:0] wr_data_b [0:255];
  always @(posedge clk) begin
    if (ifb.a_chipselect && ifb.a_write) wr_data_b[wr_cnt_b[7:0]] <= ifb.a_writedata;
  end

  function automatic logic [7:0] dut_b_data(input int idx);
    return wr_data_b[idx[7:0]];
  endfunction

  task automatic test_address_seq();
    int wstart;
    int start;
    int idx;
    int exp_seq [8] = '{6, 0, 1, 2, 7, 3, 4, 5};
    for (int k = 0; k < B_NOUT * B_NIN + B_NOUT; k++) wmem_b[k] = 8'($urandom);
    for (int k = 0; k < B_NIN; k++) ain_b[k] = 8'($urandom);
    wstart = wl_cnt_b;
    start = wr_cnt_b;
    ifb.ready = 1'b1;
    for (int k = 0; k < BOUND; k++) begin
      tick();
      if (ifb.done === 1'b1) break;
    end
    ifb.ready = 1'b0;
    n_checks++;
    if (wl_cnt_b - wstart !== 8) begin
      n_fail++;
      $display("FAIL addr_count: got %0d weight reads expected 8", wl_cnt_b - wstart);
    end
    for (int k = 0; k < 8; k++) begin
      idx = wstart + k;
      n_checks++;
      if (int'(wlog_b[idx[7:0]]) !== exp_seq[k]) begin
        n_fail++;
        $display("FAIL addr_seq_%0d: got %0d expected %0d", k, wlog_b[idx[7:0]], exp_seq[k]);
      end
    end
    n_checks++;
    if (wr_cnt_b - start !== 2) begin
      n_fail++;
      $display("FAIL addr_write_count: got %0d expected 2", wr_cnt_b - start);
    end
    for (int j = 0; j < 2; j++) begin
      idx = start + j;
      n_checks++;
      if (int'(wr_addr_b[idx[7:0]]) !== B_OUT + j) begin
        n_fail++;
        $display("FAIL addr_write_%0d: got %0d expected %0d", j, wr_addr_b[idx[7:0]], B_OUT + j);
      end
    end
    tick();
    n_checks++;
    if (viol_a !== 0 || viol_b !== 0) begin
      n_fail++;
      $display("FAIL read_write_overlap: got %0d/%0d expected 0/0", viol_a, viol_b);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_random();
    test_handshake();
    test_reset_mid_job();
    test_bias_shift();
    test_address_seq();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
